// File: rtl/gshare_predictor.sv
// gshare_predictor: gshare branch direction predictor for the IF stage.
// A table of CTR_W-bit saturating counters is indexed by the fetch PC XORed
// with a global history register (GHR). The GHR is shifted speculatively at
// fetch and repaired from EX on a mispredict. After reset, the table is
// swept to weakly-taken over 2^INDEX_W cycles. During the sweep, ready is low.
//
// Ports:
//   clk, reset          clock and asynchronous active-high reset
//   ready               init sweep complete
//   pc_if               fetch PC
//   predict_enable      lookup valid this cycle
//   spec_shift          fetched insn is a conditional branch (shift GHR)
//   prediction          predicted taken (combinational)
//   predict_strength    raw counter value (combinational)
//   predict_ghr         GHR used for this lookup (combinational)
//   update_enable       resolved-branch update valid
//   is_branch           resolved insn is a conditional branch
//   pc_update           PC of the resolved branch
//   update_ghr          predict_ghr captured at fetch for that branch
//   branch_taken        actual outcome
//   mispredict          predicted direction was wrong
//   perf_pred           resolved-branch count (only with GSHARE_PERF_CNT_EN)
//   perf_mispred        mispredict count (only with GSHARE_PERF_CNT_EN)
//
// Optional feature macro: GSHARE_PERF_CNT_EN adds the two performance counters.
module gshare_predictor #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned INDEX_W = 6,
  parameter int unsigned HIST_W  = 6,
  parameter int unsigned CTR_W   = 2
) (
  input  logic              clk,
  input  logic              reset,
  output logic              ready,
  input  logic [XLEN-1:0]   pc_if,
  input  logic              predict_enable,
  input  logic              spec_shift,
  output logic              prediction,
  output logic [CTR_W-1:0]  predict_strength,
  output logic [HIST_W-1:0] predict_ghr,
  input  logic              update_enable,
  input  logic              is_branch,
  input  logic [XLEN-1:0]   pc_update,
  input  logic [HIST_W-1:0] update_ghr,
  input  logic              branch_taken,
  input  logic              mispredict
`ifdef GSHARE_PERF_CNT_EN
  ,
  output logic [31:0]       perf_pred,
  output logic [31:0]       perf_mispred
`endif
);

  localparam int unsigned DEPTH = 1 << INDEX_W;
  localparam logic [CTR_W-1:0] WEAK_T   = {1'b1, {(CTR_W-1){1'b0}}};
  localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0] CTR_ZERO = {CTR_W{1'b0}};

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]         state, next_state;
  logic [INDEX_W-1:0] ptr, next_ptr;
  logic [HIST_W-1:0]  ghr, next_ghr;
  logic               next_ready;

  logic [CTR_W-1:0]   tbl [DEPTH];

  logic [INDEX_W-1:0] pidx, uidx;
  logic               upd_fire;
  logic [CTR_W-1:0]   ucur, unext;

  // Upper/lower PC bits do not take part in indexing.
  logic unused_bits;
  assign unused_bits = ^{pc_if[XLEN-1:INDEX_W+2], pc_if[1:0],
                         pc_update[XLEN-1:INDEX_W+2], pc_update[1:0]};

  // gshare index: word-aligned PC bits XOR zero-extended history.
  assign pidx = pc_if[INDEX_W+1:2] ^ INDEX_W'(ghr);
  assign uidx = pc_update[INDEX_W+1:2] ^ INDEX_W'(update_ghr);

  assign upd_fire = (state == ST_RUN) && update_enable && is_branch;

  // Lookup: combinational read, zeroed when not ready or not enabled.
  always_comb begin
    prediction       = 1'b0;
    predict_strength = CTR_ZERO;
    predict_ghr      = {HIST_W{1'b0}};
    if (ready && predict_enable) begin
      predict_strength = tbl[pidx];
      prediction       = predict_strength[CTR_W-1];
      predict_ghr      = ghr;
    end
  end

  // Saturating counter step for the resolved branch.
  always_comb begin
    ucur  = tbl[uidx];
    unext = ucur;
    if (branch_taken) begin
      if (ucur != CTR_MAX) unext = ucur + CTR_W'(1);
    end else begin
      if (ucur != CTR_ZERO) unext = ucur - CTR_W'(1);
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_INIT;
      ptr   <= {INDEX_W{1'b0}};
      ghr   <= {HIST_W{1'b0}};
      ready <= 1'b0;
    end else begin
      state <= next_state;
      ptr   <= next_ptr;
      ghr   <= next_ghr;
      ready <= next_ready;
    end
  end

  // Next state: sweep in INIT; GHR repair beats speculative shift in RUN.
  // Concatenate-then-truncate drops the oldest bit and also covers HIST_W=1.
  always_comb begin
    next_state = state;
    next_ptr   = ptr;
    next_ghr   = ghr;
    next_ready = ready;
    if (state == ST_INIT) begin
      next_ptr = ptr + INDEX_W'(1);
      if (&ptr) begin
        next_state = ST_RUN;
        next_ready = 1'b1;
      end
    end else begin
      if (upd_fire && mispredict)
        next_ghr = HIST_W'({update_ghr, branch_taken});
      else if (predict_enable && spec_shift)
        next_ghr = HIST_W'({ghr, prediction});
    end
  end

  // Counter table: no reset; filled by the sweep, then trained by updates.
  always_ff @(posedge clk) begin
    if (state == ST_INIT)
      tbl[ptr] <= WEAK_T;
    else if (upd_fire)
      tbl[uidx] <= unext;
  end

`ifdef GSHARE_PERF_CNT_EN
  // Resolved-branch and mispredict counters, wrap naturally at 2^32.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_pred    <= 32'd0;
      perf_mispred <= 32'd0;
    end else if (upd_fire) begin
      perf_pred <= perf_pred + 32'd1;
      if (mispredict) perf_mispred <= perf_mispred + 32'd1;
    end
  end
`endif

endmodule
